// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit; the decode and
// hazard logic imports the same constants for stall generation.
package muldiv_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step
// over a shared 2*WIDTH accumulator ({hi, lo} = product, or {rem, quotient}).
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, consumed LSB first.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    // Divide: remainder stays below b, so the WIDTH+1 bit trial value never overflows.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b};
    if (is_div) begin
      if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: IDLE -> RUN (WIDTH iterations) -> DONE.
// Handshake: start is sampled only in IDLE; busy is high exactly in RUN; done pulses for one cycle with result valid.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   final_result;
  logic               final_dbz;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_q[1]),
    .acc      (acc),
    .a        (a_q),
    .b        (b_q),
    .acc_next (acc_next)
  );

  always_comb begin
    final_dbz = op_q[1] && (b_q == '0);
    case (op_q)
      OP_MUL:   final_result = acc_next[WIDTH-1:0];
      OP_MULHU: final_result = acc_next[2*WIDTH-1:WIDTH];
      OP_DIVU:  final_result = final_dbz ? '1 : acc_next[WIDTH-1:0];
      OP_REMU:  final_result = final_dbz ? a_q : acc_next[2*WIDTH-1:WIDTH];
      default:  final_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= op;
            cnt   <= '0;
            // Upper half cleared; lower half seeded with the operand consumed bit-serially.
            acc   <= op[1] ? {{WIDTH{1'b0}}, in_a} : {{WIDTH{1'b0}}, in_b};
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            result      <= final_result;
            div_by_zero <= final_dbz;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: timeline/arithmetic reference model checked every cycle,
// directed literal cases, randomized operations and a mid-run reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .in_a        (in_a),
    .in_b        (in_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return {1'b0, p[W-1:0]};
      2'd1:    return {1'b0, p[2*W-1:W]};
      2'd2:    return (b == '0) ? {1'b1, {W{1'b1}}} : {1'b0, a / b};
      default: return (b == '0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  // Scoreboard: {div_by_zero, result} expected for each accepted start.
  logic [W:0]   exp_q[$];
  int           m_phase = 0;  // 0 waiting, 1 iterating, 2 completion cycle
  int           m_left  = 0;
  logic [W-1:0] m_result = '0;
  logic         m_dbz    = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase  = 0;
      m_left   = 0;
      m_result = '0;
      m_dbz    = 1'b0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          exp_q.push_back(ref_op(op, in_a, in_b));
          m_left  = W;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            {m_dbz, m_result} = exp_q.pop_front();
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle once the first edge has happened.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", W'(busy), W'(m_phase == 1));
      check("done", W'(done), W'(m_phase == 2));
      check("result", result, m_result);
      check("div_by_zero", W'(div_by_zero), W'(m_dbz));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_dbz,
                        input bit jam);
    int i;
    int busy_n;
    @(negedge clk);
    op = o; in_a = a; in_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_a = $urandom; in_b = $urandom; op = 2'($urandom_range(0, 3));
    i = 1;
    busy_n = 0;
    while (!done && i < W + 10) begin
      if (busy) busy_n++;
      if (jam && i == 5) begin start = 1'b1; in_a = $urandom; in_b = $urandom; end
      if (jam && i == 6) start = 1'b0;
      @(negedge clk);
      i++;
    end
    check({name, "_latency"}, W'(done ? i : 0), W'(W + 1));
    check({name, "_busy_cycles"}, W'(busy_n), W'(W));
    check({name, "_result"}, result, exp_res);
    check({name, "_dbz"}, W'(div_by_zero), W'(exp_dbz));
    @(negedge clk);
    check({name, "_done_one_cycle"}, W'(done), W'(0));
  endtask

  task automatic rand_op();
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   r;
    int t;
    o = 2'($urandom_range(0, 3));
    a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
    case ($urandom_range(0, 4))
      0:       b = '0;
      1:       b = W'($urandom_range(1, 15));
      default: b = W'($urandom);
    endcase
    r = ref_op(o, a, b);
    op = o; in_a = a; in_b = b; start = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 4);
    start = 1'b0;
    check("rand_accept", W'(busy), W'(1));
    in_a = $urandom; in_b = $urandom;
    t = 0;
    while (!done && t < W + 5) begin
      @(negedge clk);
      t++;
    end
    check("rand_done_seen", W'(done), W'(1));
    check("rand_result", result, r[W-1:0]);
    check("rand_dbz", W'(div_by_zero), W'(r[W]));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; op = 2'd0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, W'(0));
    check("reset_dbz", W'(div_by_zero), W'(0));
    rst = 1'b0;

    run_op("mul_7x6",       2'd0, 32'd7,          32'd6,          32'd42,         1'b0, 1'b0);
    run_op("mulhu_ones",    2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 1'b0);
    run_op("mul_ones",      2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 1'b0);
    run_op("divu_100_7",    2'd2, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0);
    run_op("remu_100_7",    2'd3, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0);
    run_op("divu_by_zero",  2'd2, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0);
    run_op("remu_by_zero",  2'd3, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1, 1'b0);
    run_op("mul_jammed",    2'd0, 32'h0000_1234,  32'h0000_0010,  32'h0001_2340,  1'b0, 1'b1);

    repeat (40) rand_op();

    // Reset in the middle of an operation.
    @(negedge clk);
    op = 2'd2; in_a = 32'd1000; in_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_result", result, W'(0));
    done_cnt = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", W'(done_cnt), W'(0));
    run_op("after_rst_mulhu", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
